// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character LCD sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_EN_HIGH,
    S_HOLD,
    S_EXEC
  } lcd_state_e;

  localparam int LCD_INIT_LEN = 4;
  localparam int LCD_IDX_W    = $clog2(LCD_INIT_LEN);

  // Function set 8-bit/2-line, display on, clear, entry mode increment.
  localparam logic [7:0] LCD_INIT_SEQ [LCD_INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  // Clear Display (01) and Return Home (02/03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter; o_zero is high once the loaded count has run out.
module lcd_delay_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)             r_cnt <= '0;
    else if (i_load)         r_cnt <= i_load_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 write sequencer: power-up wait, init sequence, then one byte per
// valid/ready handshake with setup / EN pulse / hold / execution timing.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC     = 2,
  parameter int EN_CYC        = 8,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 1000,
  parameter int LONG_EXEC_CYC = 40000,
  parameter int POWERUP_CYC   = 375000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, EN_CYC), max2(HOLD_CYC, EXEC_CYC)),
                                max2(LONG_EXEC_CYC, POWERUP_CYC));
  localparam int CW = $clog2(MAX_CYC + 1);

  // A phase of N cycles loads N-1 on entry and leaves when the count is zero.
  // The execution wait is measured up to the next INIT/accept cycle, so S_EXEC
  // itself runs one cycle short; power-up counts from reset release.
  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_EXEC  = CW'((EXEC_CYC > 1) ? EXEC_CYC - 2 : 0);
  localparam logic [CW-1:0] LD_LONG  = CW'((LONG_EXEC_CYC > 1) ? LONG_EXEC_CYC - 2 : 0);
  localparam logic [CW-1:0] LD_PWR   = CW'((POWERUP_CYC > 1) ? POWERUP_CYC - 2 : 0);

  lcd_state_e             r_state, w_next;
  logic                   r_on, r_ready, r_en, r_rs, r_init_done, r_init_last;
  logic [7:0]             r_data;
  logic [LCD_IDX_W-1:0]   r_idx;
  logic                   w_load, w_zero, w_take_req, w_take_init, w_set_done;
  logic [CW-1:0]          w_load_val;

  lcd_delay_timer #(.W(CW)) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_take_req  = 1'b0;
    w_take_init = 1'b0;
    w_set_done  = 1'b0;
    case (r_state)
      S_POWERUP: begin
        if (!r_on) begin
          if (POWERUP_CYC > 1) begin
            w_load     = 1'b1;
            w_load_val = LD_PWR;
          end else begin
            w_next = S_INIT;
          end
        end else if (w_zero) begin
          w_next = S_INIT;
        end
      end
      S_INIT: begin
        w_take_init = 1'b1;
        w_next      = S_SETUP;
        w_load      = 1'b1;
        w_load_val  = LD_SETUP;
      end
      S_IDLE: begin
        if (i_valid && r_ready) begin
          w_take_req = 1'b1;
          w_next     = S_SETUP;
          w_load     = 1'b1;
          w_load_val = LD_SETUP;
        end
      end
      S_SETUP: begin
        if (w_zero) begin
          w_next     = S_EN_HIGH;
          w_load     = 1'b1;
          w_load_val = LD_EN;
        end
      end
      S_EN_HIGH: begin
        if (w_zero) begin
          w_next     = S_HOLD;
          w_load     = 1'b1;
          w_load_val = LD_HOLD;
        end
      end
      S_HOLD: begin
        if (w_zero) begin
          w_next     = S_EXEC;
          w_load     = 1'b1;
          w_load_val = is_long_cmd(r_rs, r_data) ? LD_LONG : LD_EXEC;
        end
      end
      S_EXEC: begin
        if (w_zero) begin
          if (!r_init_done && !r_init_last) begin
            w_next = S_INIT;
          end else begin
            w_next     = S_IDLE;
            w_set_done = 1'b1;
          end
        end
      end
      default: w_next = S_POWERUP;
    endcase
  end

  // Outputs are registered from the next state so the pins never glitch.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_POWERUP;
      r_on        <= 1'b0;
      r_ready     <= 1'b0;
      r_en        <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_idx       <= '0;
      r_init_last <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_on    <= 1'b1;
      r_ready <= (w_next == S_IDLE);
      r_en    <= (w_next == S_EN_HIGH);
      if (w_take_init) begin
        r_rs        <= 1'b0;
        r_data      <= LCD_INIT_SEQ[r_idx];
        r_idx       <= r_idx + 1'b1;
        r_init_last <= (r_idx == LCD_IDX_W'(LCD_INIT_LEN - 1));
      end else if (w_take_req) begin
        r_rs   <= i_rs;
        r_data <= i_data;
      end
      if (w_set_done) r_init_done <= 1'b1;
    end
  end

  assign o_ready     = r_ready;
  assign o_init_done = r_init_done;
  assign o_lcd_on    = r_on;
  assign o_lcd_en    = r_en;
  assign o_lcd_rs    = r_rs;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_data  = r_data;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl with shortened timing parameters.
module tb_lcd_hd44780_ctrl;

  logic       clk = 1'b0;
  logic       rst, valid, rs;
  logic [7:0] data;
  logic       ready, init_done, lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit rw_bad = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (lcd_rw !== 1'b0) rw_bad = 1'b1;

  lcd_hd44780_ctrl #(
    .SETUP_CYC(2), .EN_CYC(4), .HOLD_CYC(2),
    .EXEC_CYC(10), .LONG_EXEC_CYC(30), .POWERUP_CYC(20)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_rs(rs), .i_data(data),
    .o_ready(ready), .o_init_done(init_done), .o_lcd_on(lcd_on),
    .o_lcd_en(lcd_en), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_data(lcd_data)
  );

  typedef struct {
    logic       rs;
    logic [7:0] dat;
    int         dly;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk($sformatf("%s ready", tag), int'(ready), 0);
    chk($sformatf("%s init_done", tag), int'(init_done), 0);
    chk($sformatf("%s lcd_on", tag), int'(lcd_on), 0);
    chk($sformatf("%s lcd_en", tag), int'(lcd_en), 0);
    chk($sformatf("%s lcd_rs", tag), int'(lcd_rs), 0);
    chk($sformatf("%s lcd_rw", tag), int'(lcd_rw), 0);
    chk($sformatf("%s lcd_data", tag), int'(lcd_data), 0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) chk($sformatf("%s wait ready timeout", tag), 0, 1);
  endtask

  // Reset, release, and watch the whole init sequence.
  task automatic run_init(input bit hold_aa);
    int         exp_rise [4] = '{23, 41, 59, 97};
    logic [7:0] exp_dat  [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    int rel, n_rise = 0, rise_at = 0, done_at = -1, ready_at = -1, acc_at = -1;
    logic prev_en = 1'b0;
    valid = hold_aa;
    rs    = hold_aa;
    data  = hold_aa ? 8'hAA : 8'h00;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("in reset");
    rst = 1'b0;
    rel = cyc;
    #1;
    chk("lcd_on before first edge", int'(lcd_on), 0);
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (cyc == rel + 1) chk("lcd_on after first edge", int'(lcd_on), 1);
      if (lcd_en && !prev_en) begin
        if (n_rise < 4) begin
          chk($sformatf("init rise %0d edge", n_rise), cyc - rel, exp_rise[n_rise]);
          chk($sformatf("init rise %0d data", n_rise), int'(lcd_data), int'(exp_dat[n_rise]));
          chk($sformatf("init rise %0d rs", n_rise), int'(lcd_rs), 0);
          chk($sformatf("init rise %0d init_done", n_rise), int'(init_done), 0);
        end else begin
          chk("post-init AA rise edge", cyc, acc_at + 2);
          chk("post-init AA data", int'(lcd_data), 8'hAA);
          chk("post-init AA rs", int'(lcd_rs), 1);
        end
        rise_at = cyc;
        n_rise++;
      end
      if (!lcd_en && prev_en) chk($sformatf("EN width %0d", n_rise - 1), cyc - rise_at, 4);
      if (init_done && done_at < 0) done_at = cyc;
      if (ready && ready_at < 0) ready_at = cyc;
      if (hold_aa && valid && ready_at >= 0 && cyc == ready_at + 1) begin
        valid  = 1'b0;
        acc_at = cyc;
      end
      prev_en = lcd_en;
    end
    chk("init_done edge", done_at - rel, 112);
    chk("ready after init edge", ready_at - rel, 112);
    chk("EN pulse count", n_rise, hold_aa ? 5 : 4);
    chk("idle at end of init run", int'(ready), 1);
  endtask

  task automatic run_xfer(input string name, input logic vrs, input logic [7:0] vdat, input int dly);
    int k, rise = -1, fall = -1, back = -1;
    wait_ready(name);
    k     = cyc;
    valid = 1'b1;
    rs    = vrs;
    data  = vdat;
    @(negedge clk);
    valid = 1'b0;
    rs    = ~vrs;
    data  = ~vdat;
    chk({name, " ready low"}, int'(ready), 0);
    chk({name, " rs latched"}, int'(lcd_rs), int'(vrs));
    chk({name, " data latched"}, int'(lcd_data), int'(vdat));
    for (int i = 2; i <= dly + 5; i++) begin
      @(negedge clk);
      if (lcd_en && rise < 0) rise = cyc;
      if (!lcd_en && rise >= 0 && fall < 0) fall = cyc;
      if (ready && back < 0) back = cyc;
    end
    chk({name, " EN rise"}, rise - k, 3);
    chk({name, " EN fall"}, fall - k, 7);
    chk({name, " ready back"}, back - k, dly);
    chk({name, " data held"}, int'(lcd_data), int'(vdat));
  endtask

  task automatic run_back_to_back();
    int k, n_rise = 0, r1 = -1, r2 = -1, rdy_at = -1, acc2 = -1;
    logic prev_en = 1'b0;
    wait_ready("b2b");
    k     = cyc;
    valid = 1'b1;
    rs    = 1'b1;
    data  = 8'h41;
    @(negedge clk);
    data = 8'h42;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (lcd_en && !prev_en) begin
        if (n_rise == 0) r1 = cyc; else r2 = cyc;
        n_rise++;
      end
      if (ready && rdy_at < 0) rdy_at = cyc;
      if (rdy_at >= 0 && acc2 < 0 && cyc == rdy_at + 1) begin
        acc2 = cyc;
        chk("b2b 42 accepted (ready low)", int'(ready), 0);
        chk("b2b 42 data", int'(lcd_data), 8'h42);
        valid = 1'b0;
      end
      prev_en = lcd_en;
    end
    chk("b2b ready rise", rdy_at - k, 18);
    chk("b2b first EN rise", r1 - k, 3);
    chk("b2b EN spacing", r2 - r1, 18);
    chk("b2b EN count", n_rise, 2);
  endtask

  task automatic run_reset_mid_en();
    int k;
    wait_ready("rst-mid");
    k     = cyc;
    valid = 1'b1;
    rs    = 1'b1;
    data  = 8'h55;
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst-mid EN high before reset", int'(lcd_en), 1);
    #1 rst = 1'b1;
    #1;
    chk_reset_vals("async reset mid-EN");
    run_init(1'b0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    vecs[0] = '{1'b1, 8'h41, 18};
    vecs[1] = '{1'b0, 8'h02, 38};
    vecs[2] = '{1'b0, 8'h80, 18};
    vecs[3] = '{1'b0, 8'h01, 38};
    vecs[4] = '{1'b0, 8'h03, 38};
    vecs[5] = '{1'b0, 8'h04, 18};
    vecs[6] = '{1'b1, 8'h01, 18};
    vecs[7] = '{1'b0, 8'h00, 18};

    valid = 1'b0;
    rs    = 1'b0;
    data  = 8'h00;
    rst   = 1'b1;
    #2;
    chk_reset_vals("power-on reset");

    run_init(1'b1);
    for (int i = 0; i < 8; i++)
      run_xfer($sformatf("vec%0d rs=%0d d=%02h", i, vecs[i].rs, vecs[i].dat),
               vecs[i].rs, vecs[i].dat, vecs[i].dly);
    run_back_to_back();
    run_reset_mid_en();
    chk("RW always 0", int'(rw_bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
